// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port 1R/1W Mem_top memory between instruction fetch (IF,
//   read-only) and load/store (LS, read/write). Round-robin arbitration, one
//   transaction in flight, read data captured a fixed MEM_LATENCY cycles after
//   the request is issued (Mem_top's sticky data_valid is ignored).
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   if_req/if_addr             IF read request, held until if_gnt
//   if_gnt/if_rsp_valid        1-cycle pulses: accepted / read data valid
//   if_rdata                   IF read data, held until next IF response
//   ls_req/ls_we/ls_addr/ls_wdata  LS request, held until ls_gnt
//   ls_gnt/ls_rsp_valid        1-cycle pulses: accepted / read data valid or write done
//   ls_rdata                   LS read data, held until next LS read response
//   mem_req_valid/mem_we/mem_addr  request to Mem_top, valid only in ISSUE
//   mem_wdata/mem_wdata_oe     write data and drive enable for the Data tri-state
//   mem_rdata                  Mem_top Data bus, read side
//   busy                       high in any state other than IDLE
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wdata_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic                  ptr_ls;      // 1: LS wins a tie, 0: IF wins a tie
  logic                  win_ls;      // owner of the transaction in flight
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] if_rdata_q, ls_rdata_q;

  logic any_req, pick_ls, arb_win, capture;

  assign any_req = if_req | ls_req;
  assign pick_ls = ls_req & (~if_req | ptr_ls);
  // IDLE and RESP both arbitrate, which is what gives back-to-back issue.
  assign arb_win = ((state == IDLE) || (state == RESP)) && any_req;
  assign capture = (state == WAIT) && (cnt == '0) && !lat_we;

  // state register and control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr_ls     <= 1'b1;
      win_ls     <= 1'b0;
      lat_we     <= 1'b0;
      cnt        <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (arb_win) begin
        win_ls <= pick_ls;
        lat_we <= pick_ls & ls_we;
        ptr_ls <= ~pick_ls;
      end
      if (state == ISSUE)
        cnt <= CNT_W'(MEM_LATENCY - 1);
      else if ((state == WAIT) && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
      if (capture) begin
        if (win_ls) ls_rdata_q <= mem_rdata;
        else        if_rdata_q <= mem_rdata;
      end
    end
  end

  // request address/data hold registers (only observed through ISSUE decode)
  always_ff @(posedge clk) begin
    if (arb_win) begin
      lat_addr  <= pick_ls ? ls_addr : if_addr;
      lat_wdata <= ls_wdata;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = any_req ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    if_gnt        = (state == ISSUE) && !win_ls;
    ls_gnt        = (state == ISSUE) &&  win_ls;
    if_rsp_valid  = (state == RESP)  && !win_ls;
    ls_rsp_valid  = (state == RESP)  &&  win_ls;
    mem_req_valid = (state == ISSUE);
    mem_we        = (state == ISSUE) && lat_we;
    mem_wdata_oe  = (state == ISSUE) && lat_we;
    mem_addr      = (state == ISSUE) ? lat_addr : '0;
    mem_wdata     = ((state == ISSUE) && lat_we) ? lat_wdata : '0;
    busy          = (state != IDLE);
  end

  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

  // A pending request must stay raised until it is granted.
  a_if_hold: assert property (@(posedge clk) disable iff (!reset)
                              (if_req && !if_gnt) |=> if_req);
  a_ls_hold: assert property (@(posedge clk) disable iff (!reset)
                              (ls_req && !ls_gnt) |=> ls_req);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // instance with MEM_LATENCY = 1
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rsp_valid, ls_gnt, ls_rsp_valid;
  logic        mem_req_valid, mem_we, mem_wdata_oe, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

  // instance with MEM_LATENCY = 3 (IF reads only)
  logic        if_req3;
  logic [31:0] if_addr3;
  logic        if_gnt3, if_rsp_valid3, ls_gnt3, ls_rsp_valid3;
  logic        mem_req_valid3, mem_we3, mem_wdata_oe3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_rsp_valid(if_rsp_valid3), .if_rdata(if_rdata3),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'd0), .ls_wdata(32'd0),
    .ls_gnt(ls_gnt3), .ls_rsp_valid(ls_rsp_valid3), .ls_rdata(ls_rdata3),
    .mem_req_valid(mem_req_valid3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wdata_oe(mem_wdata_oe3), .mem_rdata(mem_rdata3),
    .busy(busy3)
  );

  // control outputs packed: busy if_gnt ls_gnt if_rsp ls_rsp req we oe
  logic [31:0] ctl1, ctl3;
  assign ctl1 = {24'd0, busy, if_gnt, ls_gnt, if_rsp_valid, ls_rsp_valid,
                 mem_req_valid, mem_we, mem_wdata_oe};
  assign ctl3 = {24'd0, busy3, if_gnt3, ls_gnt3, if_rsp_valid3, ls_rsp_valid3,
                 mem_req_valid3, mem_we3, mem_wdata_oe3};

  // memory model: read data is stable exactly LAT cycles after the request,
  // garbage before that
  logic [31:0] mem1 [0:63];
  logic [31:0] word1;
  int          cnt1;
  always @(posedge clk) begin
    if (!reset) begin
      mem1[0] <= 32'h00100293;
      mem1[3] <= 32'hCAFEF00D;
      cnt1    <= 0;
    end else if (mem_req_valid) begin
      if (mem_we && mem_wdata_oe) mem1[mem_addr[5:0]] <= mem_wdata;
      else if (!mem_we) begin
        word1 <= mem1[mem_addr[5:0]];
        cnt1  <= 1;
      end
    end else if (cnt1 > 1) cnt1 <= cnt1 - 1;
  end
  assign mem_rdata = (cnt1 == 1) ? word1 : 32'hBAD0BAD0;

  logic [31:0] mem3 [0:63];
  logic [31:0] word3;
  int          cnt3;
  always @(posedge clk) begin
    if (!reset) begin
      mem3[0] <= 32'h00200313;
      cnt3    <= 0;
    end else if (mem_req_valid3 && !mem_we3) begin
      word3 <= mem3[mem_addr3[5:0]];
      cnt3  <= 3;
    end else if (cnt3 > 1) cnt3 <= cnt3 - 1;
  end
  assign mem_rdata3 = (cnt3 == 1) ? word3 : 32'hBAD0BAD0;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // expected control patterns
  localparam logic [31:0] C_IDLE  = 32'h00;
  localparam logic [31:0] C_IF_IS = 32'hC4;
  localparam logic [31:0] C_LS_RD = 32'hA4;
  localparam logic [31:0] C_LS_WR = 32'hA7;
  localparam logic [31:0] C_WAIT  = 32'h80;
  localparam logic [31:0] C_IF_RS = 32'h90;
  localparam logic [31:0] C_LS_RS = 32'h88;

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    if_req3 = 0; if_addr3 = 0;
    #1 reset = 1'b0;
    repeat (3) nxt();

    // reset state
    check("rst_ctl", ctl1, C_IDLE);
    check("rst_ifd", if_rdata, 32'd0);
    check("rst_lsd", ls_rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ctl3", ctl3, C_IDLE);
    reset = 1'b1;
    nxt();

    // IF read of address 0
    if_req = 1; if_addr = 32'd0;
    check("t1_idle", ctl1, C_IDLE);
    nxt(); check("t1_issue", ctl1, C_IF_IS);
    nxt(); if_req = 0; check("t1_wait", ctl1, C_WAIT);
    nxt(); check("t1_resp", ctl1, C_IF_RS); check("t1_data", if_rdata, 32'h00100293);
    nxt(); check("t1_idle2", ctl1, C_IDLE); check("t1_hold", if_rdata, 32'h00100293);

    // LS write then LS read of address 10
    ls_req = 1; ls_we = 1; ls_addr = 32'd10; ls_wdata = 32'hDEADBEEF;
    nxt(); check("t2_wr_issue", ctl1, C_LS_WR);
    check("t2_wr_addr", mem_addr, 32'd10); check("t2_wr_data", mem_wdata, 32'hDEADBEEF);
    nxt(); ls_req = 0; check("t2_wr_wait", ctl1, C_WAIT); check("t2_wr_wd0", mem_wdata, 32'd0);
    nxt(); check("t2_wr_resp", ctl1, C_LS_RS); check("t2_wr_rd", ls_rdata, 32'd0);
    nxt(); ls_req = 1; ls_we = 0; check("t2_idle", ctl1, C_IDLE);
    nxt(); check("t2_rd_issue", ctl1, C_LS_RD); check("t2_rd_addr", mem_addr, 32'd10);
    nxt(); ls_req = 0; check("t2_rd_wait", ctl1, C_WAIT);
    nxt(); check("t2_rd_resp", ctl1, C_LS_RS); check("t2_rd_data", ls_rdata, 32'hDEADBEEF);
    nxt(); check("t2_idle2", ctl1, C_IDLE);

    // reset during WAIT of an LS read
    ls_req = 1; ls_we = 0; ls_addr = 32'd10;
    nxt(); check("t4_issue", ctl1, C_LS_RD);
    nxt(); ls_req = 0; check("t4_wait", ctl1, C_WAIT);
    #2 reset = 1'b0;
    #1;
    check("t4_rst_ctl", ctl1, C_IDLE);
    check("t4_rst_lsd", ls_rdata, 32'd0);
    check("t4_rst_ifd", if_rdata, 32'd0);
    check("t4_rst_addr", mem_addr, 32'd0);
    nxt(); check("t4_rst_c1", ctl1, C_IDLE);
    nxt(); check("t4_rst_c2", ctl1, C_IDLE);
    reset = 1'b1;
    if_req = 1; if_addr = 32'd3;
    nxt(); check("t4_if_issue", ctl1, C_IF_IS); check("t4_if_addr", mem_addr, 32'd3);
    nxt(); if_req = 0; check("t4_if_wait", ctl1, C_WAIT);
    nxt(); check("t4_if_resp", ctl1, C_IF_RS); check("t4_if_data", if_rdata, 32'hCAFEF00D);
    check("t4_ls_kept0", ls_rdata, 32'd0);
    nxt(); check("t4_idle", ctl1, C_IDLE);

    // both requesters held: LS, IF, LS, IF, LS, IF, then LS drains
    if_req = 1; if_addr = 32'd0; ls_req = 1; ls_we = 0; ls_addr = 32'd10;
    for (int k = 1; k <= 21; k++) begin
      int  g, ph;
      bit  exp_ls;
      nxt();
      if (k == 17) if_req = 0;
      if (k == 20) ls_req = 0;
      g = (k - 1) / 3;
      ph = (k - 1) % 3;
      exp_ls = (g % 2 == 0);
      if (ph == 0)
        check($sformatf("t3_issue_k%0d", k), ctl1, exp_ls ? C_LS_RD : C_IF_IS);
      else if (ph == 1)
        check($sformatf("t3_wait_k%0d", k), ctl1, C_WAIT);
      else begin
        check($sformatf("t3_resp_k%0d", k), ctl1, exp_ls ? C_LS_RS : C_IF_RS);
        if (exp_ls) check($sformatf("t3_lsd_k%0d", k), ls_rdata, 32'hDEADBEEF);
        else        check($sformatf("t3_ifd_k%0d", k), if_rdata, 32'h00100293);
      end
    end
    nxt(); check("t3_idle", ctl1, C_IDLE);

    // LS re-requests in its RESP cycle: back-to-back issue
    ls_req = 1; ls_we = 1; ls_addr = 32'd20; ls_wdata = 32'h5A5A0011;
    nxt(); check("t6_wr_issue", ctl1, C_LS_WR);
    nxt(); ls_req = 0; check("t6_wr_wait", ctl1, C_WAIT);
    nxt(); ls_req = 1; ls_we = 0; check("t6_wr_resp", ctl1, C_LS_RS);
    nxt(); check("t6_rd_issue", ctl1, C_LS_RD); check("t6_rd_addr", mem_addr, 32'd20);
    nxt(); ls_req = 0; check("t6_rd_wait", ctl1, C_WAIT);
    nxt(); check("t6_rd_resp", ctl1, C_LS_RS); check("t6_rd_data", ls_rdata, 32'h5A5A0011);
    nxt(); check("t6_idle", ctl1, C_IDLE);

    // MEM_LATENCY = 3 IF read
    if_req3 = 1; if_addr3 = 32'd0;
    check("t5_idle", ctl3, C_IDLE);
    nxt(); check("t5_issue", ctl3, C_IF_IS);
    nxt(); if_req3 = 0; check("t5_wait1", ctl3, C_WAIT);
    nxt(); check("t5_wait2", ctl3, C_WAIT);
    nxt(); check("t5_wait3", ctl3, C_WAIT);
    nxt(); check("t5_resp", ctl3, C_IF_RS); check("t5_data", if_rdata3, 32'h00200313);
    nxt(); check("t5_idle2", ctl3, C_IDLE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
